imm_ext_pipe: RTL and testbench

Parametrised, pipelined immediate extender for the CPU decode/execute boundary. It takes an IN_W-bit instruction immediate plus a 2-bit extension mode and produces an OUT_W-bit operand through a registered output stage. The stage includes a 2-entry skid buffer with a valid/ready handshake and a synchronous flush, so a stalled execute stage never drops an immediate. An optional tag (PC or instruction ID) travels alongside each immediate.

---
 rtl/imm_ext_pipe.sv | 114 +++++++++++
 tb/tb_imm_ext_pipe.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_pipe.sv
// Immediate extender with a registered output and a 2-entry skid buffer.
// in_ready depends only on skid occupancy, so there is no combinational path from out_ready.
module imm_ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int EXT_W = OUT_W - IN_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            st, st_nxt;
    logic [OUT_W-1:0]  ext, sext;
    logic [OUT_W-1:0]  skid_data;
    logic [TAG_W-1:0]  skid_tag;
    logic              in_xfer, out_xfer;
    logic              load_main, load_skid, move_skid;

    assign sext = {{EXT_W{in_imm[IN_W-1]}}, in_imm};

    always_comb begin
        ext = '0;
        unique case (in_mode)
            2'b00:   ext = {{EXT_W{1'b0}}, in_imm};
            2'b01:   ext = sext;
            2'b10:   ext = {in_imm, {EXT_W{1'b0}}};
            default: ext = {sext[OUT_W-3:0], 2'b00};
        endcase
    end

    assign out_valid = (st != EMPTY);
    assign in_ready  = (st != FULL);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        st_nxt    = st;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        if (flush) begin
            // flush wins: any concurrent input is dropped, any output counts as consumed
            st_nxt = EMPTY;
        end else begin
            unique case (st)
                EMPTY: if (in_xfer) begin
                    st_nxt    = ONE;
                    load_main = 1'b1;
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        load_main = 1'b1;
                    end else if (in_xfer) begin
                        st_nxt    = FULL;
                        load_skid = 1'b1;
                    end else if (out_xfer) begin
                        st_nxt = EMPTY;
                    end
                end
                FULL: if (out_xfer) begin
                    st_nxt    = ONE;
                    move_skid = 1'b1;
                end
                default: st_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= EMPTY;
        else        st <= st_nxt;
    end

    // Data/tag registers move only on a transfer; flush clears just the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_tag   <= '0;
            skid_data <= '0;
            skid_tag  <= '0;
        end else begin
            if (load_main) begin
                out_data <= ext;
                out_tag  <= in_tag;
            end else if (move_skid) begin
                out_data <= skid_data;
                out_tag  <= skid_tag;
            end
            if (load_skid) begin
                skid_data <= ext;
                skid_tag  <= in_tag;
            end
        end
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe: default widths plus a 12->20 bit variant.
module tb_imm_ext_pipe;

    logic        clk, rst_n;
    logic        flush, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic [7:0]  in_tag, out_tag;
    logic [31:0] out_data;

    logic        p_in_valid, p_in_ready, p_out_valid;
    logic [11:0] p_in_imm;
    logic [1:0]  p_in_mode;
    logic [7:0]  p_out_tag;
    logic [19:0] p_out_data;

    int vecs = 0;
    int errs = 0;

    imm_ext_pipe dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    imm_ext_pipe #(.IN_W(12), .OUT_W(20), .TAG_W(8)) dut_p (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(p_in_valid), .in_ready(p_in_ready), .in_imm(p_in_imm),
        .in_mode(p_in_mode), .in_tag(8'h00),
        .out_valid(p_out_valid), .out_ready(1'b1),
        .out_data(p_out_data), .out_tag(p_out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // inputs change and outputs are sampled 1ns after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 0; in_valid = 0; out_ready = 0;
        in_imm = '0; in_mode = '0; in_tag = '0;
        p_in_valid = 0; p_in_imm = '0; p_in_mode = '0;
        #12;
        vecs++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 8'h0 || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset: valid=%b data=%h tag=%h rdy=%b, want 0/0/0/1", out_valid, out_data, out_tag, in_ready);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_modes();
        logic [15:0] imms [6]  = '{16'h8004, 16'h8004, 16'h8004, 16'h8004, 16'h7FFF, 16'h7FFF};
        logic [1:0]  modes [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b11};
        logic [31:0] exps [6]  = '{32'h00008004, 32'hFFFF8004, 32'h80040000,
                                   32'hFFFE0010, 32'h00007FFF, 32'h0001FFFC};
        out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1; in_imm = imms[i]; in_mode = modes[i]; in_tag = 8'(i);
            tick();
            vecs++;
            if (out_valid !== 1'b1 || out_data !== exps[i]) begin
                errs++;
                $display("FAIL mode%0d imm=%h: valid=%b data=%h, want 1/%h", i, imms[i], out_valid, out_data, exps[i]);
            end
        end
        in_valid = 0;
        tick();
    endtask

    task automatic test_stream();
        out_ready = 1; in_mode = 2'b00;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; in_tag = 8'(i); in_imm = 16'(i * 3);
            tick();
            vecs++;
            if (out_valid !== 1'b1 || out_tag !== 8'(i) || out_data !== 32'(i * 3) || in_ready !== 1'b1) begin
                errs++;
                $display("FAIL stream[%0d]: valid=%b tag=%h data=%h rdy=%b, want 1/%h/%h/1", i, out_valid, out_tag, out_data, in_ready, i, i * 3);
            end
        end
        in_valid = 0;
        tick();
        vecs++;
        if (out_valid !== 1'b0) begin
            errs++;
            $display("FAIL stream_end: valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_tag [6] = '{8'hA0, 8'hA0, 8'hA0, 8'hB0, 8'hC0, 8'hC0};
        logic       exp_vld [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       exp_rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        out_ready = 0; in_mode = 2'b01;
        for (int i = 0; i < 6; i++) begin
            in_valid  = (i < 5);
            in_tag    = (i == 0) ? 8'hA0 : (i == 1) ? 8'hB0 : 8'hC0;
            in_imm    = {in_tag, 8'h00};
            out_ready = (i >= 3);
            tick();
            vecs++;
            if (out_valid !== exp_vld[i] || in_ready !== exp_rdy[i] || (exp_vld[i] && out_tag !== exp_tag[i])) begin
                errs++;
                $display("FAIL bp[%0d]: valid=%b rdy=%b tag=%h, want %b/%b/%h", i, out_valid, in_ready, out_tag, exp_vld[i], exp_rdy[i], exp_tag[i]);
            end
        end
        vecs++;
        if (out_data !== 32'hFFFFC000) begin
            errs++;
            $display("FAIL bp_data: data=%h, want ffffc000", out_data);
        end
        in_valid = 0;
    endtask

    task automatic test_flush();
        out_ready = 0; in_mode = 2'b00;
        in_valid = 1; in_tag = 8'h11; in_imm = 16'h0011; tick();
        in_tag = 8'h22; in_imm = 16'h0022; tick();
        vecs++;
        if (in_ready !== 1'b0) begin
            errs++;
            $display("FAIL flush_fill: rdy=%b, want 0", in_ready);
        end
        flush = 1; in_tag = 8'hDD; in_imm = 16'h00DD; tick();
        flush = 0; in_valid = 0;
        vecs++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_tag !== 8'h11 || out_data !== 32'h11) begin
            errs++;
            $display("FAIL flush: valid=%b rdy=%b tag=%h data=%h, want 0/1/11/11", out_valid, in_ready, out_tag, out_data);
        end
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vecs++;
            if (out_valid !== 1'b0 || out_tag === 8'hDD) begin
                errs++;
                $display("FAIL flush_after[%0d]: valid=%b tag=%h, want 0/not dd", i, out_valid, out_tag);
            end
        end
    endtask

    task automatic test_async_reset();
        out_ready = 0; in_mode = 2'b00;
        in_valid = 1; in_tag = 8'h55; in_imm = 16'h1234; tick();
        in_valid = 0;
        #2 rst_n = 0;
        #1;
        vecs++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 8'h0 || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL async_rst: valid=%b data=%h tag=%h rdy=%b, want 0/0/0/1", out_valid, out_data, out_tag, in_ready);
        end
        #2 rst_n = 1;
        tick();
        in_valid = 1; in_tag = 8'h66; in_imm = 16'h4321; tick();
        in_valid = 0;
        vecs++;
        if (out_valid !== 1'b1 || out_tag !== 8'h66 || out_data !== 32'h4321) begin
            errs++;
            $display("FAIL post_rst: valid=%b tag=%h data=%h, want 1/66/4321", out_valid, out_tag, out_data);
        end
        out_ready = 1; tick();
    endtask

    task automatic test_param();
        p_in_valid = 1; p_in_imm = 12'hFFF; p_in_mode = 2'b11; tick();
        vecs++;
        if (p_out_valid !== 1'b1 || p_out_data !== 20'hFFFFC) begin
            errs++;
            $display("FAIL p_mode11: valid=%b data=%h, want 1/ffffc", p_out_valid, p_out_data);
        end
        p_in_mode = 2'b10; tick();
        vecs++;
        if (p_out_data !== 20'hFFF00) begin
            errs++;
            $display("FAIL p_mode10: data=%h, want fff00", p_out_data);
        end
        p_in_imm = 12'h800; p_in_mode = 2'b01; tick();
        vecs++;
        if (p_out_data !== 20'hFF800) begin
            errs++;
            $display("FAIL p_mode01: data=%h, want ff800", p_out_data);
        end
        p_in_valid = 0; tick();
    endtask

    initial begin
        test_reset();
        test_modes();
        test_stream();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_param();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
